seg7_scan: RTL and testbench

- Display-side consumer of the clock's BCD digit counters: takes four BCD digits (hour tens, hour units, minute tens, minute units) and drives the Basys2 4-digit common-anode seven-segment display by time multiplexing.
- Snapshots all four digits once per scan frame so a digit cannot tear mid-frame.
- Supports per-digit blink for time-set mode, per-digit decimal point, and leading-zero blanking on the hour-tens digit.

---
 rtl/seg7_scan.sv | 92 +++++++++
 tb/tb_seg7_scan.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/seg7_scan.sv
// seg7_scan: time-multiplexed driver for a 4-digit common-anode seven-segment display.
// Ports: clk/clr (clr async active-high); d3..d0 BCD digits (d3 leftmost);
//        blink/dp_en per-digit masks; lz_blank blanks digit 3 when it is 0;
//        an anode selects, seg segments (a=bit0), dp decimal point, all active low.
module seg7_scan #(
    parameter int SCAN_DIV    = 50000,
    parameter int BLINK_TICKS = 250
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [3:0] d3,
    input  logic [3:0] d2,
    input  logic [3:0] d1,
    input  logic [3:0] d0,
    input  logic [3:0] blink,
    input  logic [3:0] dp_en,
    input  logic       lz_blank,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);
    localparam int PW = $clog2(SCAN_DIV);
    localparam int BW = BLINK_TICKS > 1 ? $clog2(BLINK_TICKS) : 1;

    logic [PW-1:0] p_q;
    logic [1:0]    sel_q;
    logic [BW-1:0] bc_q;
    logic          ph_q;
    logic [3:0]    s_q [4];
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic          tick, blank;
    logic [3:0]    dig;

    function automatic logic [6:0] decode(input logic [3:0] v);
        case (v)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    assign tick  = p_q == PW'(SCAN_DIV - 1);
    assign dig   = s_q[sel_q];
    assign blank = (blink[sel_q] && ph_q) || (sel_q == 2'd3 && lz_blank && dig == 4'd0);

    always_comb begin
        an_d  = blank ? 4'b1111 : ~(4'b0001 << sel_q);
        seg_d = blank ? 7'b1111111 : decode(dig);
        dp_d  = blank ? 1'b1 : ~dp_en[sel_q];
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            p_q   <= '0;
            sel_q <= '0;
            bc_q  <= '0;
            ph_q  <= 1'b0;
            s_q   <= '{default: '0};
            an_q  <= 4'b1111;
            seg_q <= 7'b1111111;
            dp_q  <= 1'b1;
        end else begin
            p_q <= tick ? '0 : p_q + 1'b1;
            if (tick) begin
                sel_q <= sel_q + 2'd1;
                bc_q  <= bc_q == BW'(BLINK_TICKS - 1) ? '0 : bc_q + 1'b1;
                if (bc_q == BW'(BLINK_TICKS - 1))
                    ph_q <= ~ph_q;
                // Frame boundary: latch all digits together so a frame never tears.
                if (sel_q == 2'd3)
                    s_q <= '{d0, d1, d2, d3};
            end
            an_q  <= an_d;
            seg_q <= seg_d;
            dp_q  <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;
endmodule

// File: tb/tb_seg7_scan.sv
// tb_seg7_scan: directed plus randomized check of seg7_scan against a cycle-count model.
module tb_seg7_scan;
    localparam int SD = 4;
    localparam int BT = 2;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic [3:0] d3 = 4'd1, d2 = 4'd2, d1 = 4'd3, d0 = 4'd4;
    logic [3:0] blink = 4'b0000;
    logic [3:0] dp_en = 4'b0000;
    logic       lz_blank = 1'b0;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    int cmp = 0;
    int errs = 0;
    int k = 0;
    logic [3:0] snap [4] = '{default: '0};
    logic [6:0] segtab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h3f, 7'h3f, 7'h3f, 7'h3f, 7'h3f, 7'h3f};

    seg7_scan #(.SCAN_DIV(SD), .BLINK_TICKS(BT)) dut (
        .clk(clk), .clr(clr), .d3(d3), .d2(d2), .d1(d1), .d0(d0),
        .blink(blink), .dp_en(dp_en), .lz_blank(lz_blank),
        .an(an), .seg(seg), .dp(dp)
    );

    always #5 clk = ~clk;

    // Output after an edge is a function of how many edges have elapsed since reset:
    // slot = tick count mod 4, blink phase = (tick count / BLINK_TICKS) mod 2.
    function automatic logic [11:0] model(input int sel, input int ph);
        logic [3:0] dg;
        dg = snap[sel];
        if ((blink[sel] && ph == 1) || (sel == 3 && lz_blank && dg == 4'd0))
            return 12'hfff;
        return {~(4'b0001 << sel), segtab[dg], ~dp_en[sel]};
    endfunction

    task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
        cmp++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s k=%0d: got an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b",
                   tag, k, got[11:8], got[7:1], got[0], exp[11:8], exp[7:1], exp[0]);
        end
    endtask

    task automatic step();
        logic [11:0] exp;
        exp = model((k / SD) % 4, (k / (SD * BT)) % 2);
        if (k % (4 * SD) == 4 * SD - 1)
            snap = '{d0, d1, d2, d3};
        @(posedge clk);
        #1;
        k++;
        check("model", {an, seg, dp}, exp);
        cmp++;
        assert ($countones(~an) <= 1) else begin
            errs++;
            $error("FAIL onehot k=%0d: got an=%b, expected at most one low bit", k, an);
        end
    endtask

    task automatic run_to(input int n);
        while (k < n) step();
    endtask

    task automatic model_reset();
        k = 0;
        snap = '{default: '0};
    endtask

    initial begin
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset_hold", {an, seg, dp}, 12'hfff);
        clr = 1'b0;
        model_reset();

        run_to(1);
        check("first_edge", {an, seg, dp}, {4'b1110, 7'b1000000, 1'b1});
        run_to(5);
        check("edge5", {an, seg, dp}, {4'b1101, 7'b1000000, 1'b1});

        run_to(17);
        check("frame_d0", {an, seg, dp}, {4'b1110, 7'b0011001, 1'b1});
        run_to(21);
        check("frame_d1", {an, seg, dp}, {4'b1101, 7'b0110000, 1'b1});
        run_to(25);
        check("frame_d2", {an, seg, dp}, {4'b1011, 7'b0100100, 1'b1});
        run_to(29);
        check("frame_d3", {an, seg, dp}, {4'b0111, 7'b1111001, 1'b1});

        run_to(33);
        check("tear_before", {an, seg, dp}, {4'b1110, 7'b0011001, 1'b1});
        run_to(37);
        d0 = 4'd9;
        run_to(41);
        check("tear_same_frame", {an, seg, dp}, {4'b1011, 7'b0100100, 1'b1});
        run_to(49);
        check("tear_next_frame", {an, seg, dp}, {4'b1110, 7'b0010000, 1'b1});

        d3 = 4'd0;
        lz_blank = 1'b1;
        run_to(77);
        check("lz_blank_on", {an, seg, dp}, 12'hfff);
        lz_blank = 1'b0;
        run_to(78);
        check("lz_blank_off", {an, seg, dp}, {4'b0111, 7'b1000000, 1'b1});

        blink = 4'b0011;
        run_to(97);
        check("blink_d0_lit", {an, seg, dp}, {4'b1110, 7'b0010000, 1'b1});
        run_to(112);
        blink = 4'b1111;
        run_to(121);
        check("blink_all_dark2", {an, seg, dp}, 12'hfff);
        run_to(128);
        check("blink_all_dark3", {an, seg, dp}, 12'hfff);

        blink = 4'b0000;
        d2 = 4'hC;
        dp_en = 4'b0100;
        run_to(149);
        check("dp_off_slot1", {an, seg, dp}, {4'b1101, 7'b0110000, 1'b1});
        run_to(153);
        check("dash_dp_slot2", {an, seg, dp}, {4'b1011, 7'b0111111, 1'b0});
        run_to(154);
        clr = 1'b1;
        #1;
        check("async_clr", {an, seg, dp}, 12'hfff);
        @(posedge clk);
        #1;
        check("clr_held", {an, seg, dp}, 12'hfff);
        clr = 1'b0;
        model_reset();
        run_to(1);
        check("restart_slot0", {an, seg, dp}, {4'b1110, 7'b1000000, 1'b0 == dp_en[0] ? 1'b1 : 1'b0});

        for (int i = 0; i < 800; i++) begin
            case ($urandom_range(0, 15))
                0: d0 = 4'($urandom_range(0, 15));
                1: d1 = 4'($urandom_range(0, 15));
                2: d2 = 4'($urandom_range(0, 15));
                3: d3 = 4'($urandom_range(0, 3));
                4: blink = 4'($urandom_range(0, 15));
                5: dp_en = 4'($urandom_range(0, 15));
                6: lz_blank = 1'($urandom_range(0, 1));
                default: ;
            endcase
            if ($urandom_range(0, 149) == 0) begin
                clr = 1'b1;
                #1;
                check("rand_clr", {an, seg, dp}, 12'hfff);
                @(posedge clk);
                #1;
                clr = 1'b0;
                model_reset();
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
        $finish;
    end
endmodule
